// File: rtl/irda_fir_pkg.sv
// Shared constants for the IrDA FIR transmit datapath: flag codes, flag chip
// patterns, CRC-32 parameters and the 4PPM symbol table.
package irda_fir_pkg;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_PA   = 2'b01,
    FLAG_STA  = 2'b10,
    FLAG_STO  = 2'b11
  } fir_flag_e;

  // Chip patterns are transmitted MSB first.
  localparam logic [15:0] PA_PATTERN  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] STA_PATTERN = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] STO_PATTERN = 32'b0000_1100_0000_1100_0000_0110_0000_0110;
  localparam int unsigned FRAME_FLAG_LEN = 32;

  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_PRESET = 32'hFFFF_FFFF;

  function automatic logic [3:0] ppm_symbol(input logic [1:0] pair);
    logic [3:0] sym;
    unique case (pair)
      2'b00:   sym = 4'b1000;
      2'b01:   sym = 4'b0100;
      2'b10:   sym = 4'b0010;
      default: sym = 4'b0001;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/irda_fir_crc32_serial.sv
// Bit-serial reflected CRC-32: accumulates data bits, then shifts out the
// complemented remainder LSB first. State moves only on the bit strobe.
module irda_fir_crc32_serial
  import irda_fir_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  input  logic clr_i,
  input  logic crcndata_i,
  input  logic din_i,
  output logic dout_o
);

  logic [31:0] crc_q, crc_d;
  logic        fb;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    fb    = crc_q[0] ^ din_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_PRESET;
    end else if (crcndata_i) begin
      // Ones shift in behind the remainder, so the output falls to 0 once it is drained.
      crc_d = {1'b1, crc_q[31:1]};
    end else begin
      crc_d = (crc_q >> 1) ^ (fb ? CRC_POLY : 32'h0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_PRESET;
    end else if (strobe_i) begin
      crc_q <= crc_d;
    end
  end

  assign dout_o = crcndata_i ? ~crc_q[0] : din_i;

endmodule

// File: rtl/irda_fir_tx_datapath.sv
// IrDA FIR transmit datapath: flag chip generator, serial CRC-32 insertion
// and 4PPM encoder.
module irda_fir_tx_datapath
  import irda_fir_pkg::*;
#(
  parameter int unsigned PA_REPEAT = 16
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       fir_tx8_enable,
  input  logic       fir_tx4_enable,
  input  logic       fir_gen_start,
  input  logic [1:0] fir_flag,
  output logic       flag_gen_o,
  output logic       eof,
  input  logic       clrcrc,
  input  logic       crcndata,
  input  logic       txdin,
  output logic       txdout,
  input  logic       ppm_restart,
  input  logic       next_data_fir,
  output logic       ppm_o
);

  localparam int unsigned PA_LEN   = 16 * PA_REPEAT;
  localparam int          PA_IDX_W = $clog2(PA_LEN + 1);
  localparam int          IDX_W    = (PA_IDX_W > 6) ? PA_IDX_W : 6;

  // ---------------- flag generator ----------------
  fir_flag_e        flag_q, flag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eof_q, eof_d;
  logic             flag_gen_q, flag_gen_d;
  logic [IDX_W-1:0] seq_len;
  logic             seq_chip;

  always_comb begin
    seq_len  = '0;
    seq_chip = 1'b0;
    unique case (flag_q)
      FLAG_PA: begin
        seq_len  = IDX_W'(PA_LEN);
        seq_chip = PA_PATTERN[~idx_q[3:0]];
      end
      FLAG_STA: begin
        seq_len  = IDX_W'(FRAME_FLAG_LEN);
        seq_chip = STA_PATTERN[~idx_q[4:0]];
      end
      FLAG_STO: begin
        seq_len  = IDX_W'(FRAME_FLAG_LEN);
        seq_chip = STO_PATTERN[~idx_q[4:0]];
      end
      default: ;
    endcase
  end

  always_comb begin
    flag_d     = flag_q;
    idx_d      = idx_q;
    eof_d      = eof_q;
    flag_gen_d = flag_gen_q;
    if (fir_gen_start) begin
      flag_d     = fir_flag_e'(fir_flag);
      idx_d      = '0;
      eof_d      = 1'b0;
      flag_gen_d = 1'b0;
    end else if (fir_tx8_enable && !eof_q) begin
      if (idx_q < seq_len) begin
        flag_gen_d = seq_chip;
        idx_d      = idx_q + IDX_W'(1);
      end else begin
        flag_gen_d = 1'b0;
        eof_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      flag_q     <= FLAG_NONE;
      idx_q      <= '0;
      eof_q      <= 1'b0;
      flag_gen_q <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      idx_q      <= idx_d;
      eof_q      <= eof_d;
      flag_gen_q <= flag_gen_d;
    end
  end

  assign flag_gen_o = flag_gen_q;
  assign eof        = eof_q;

  // ---------------- CRC insertion ----------------
  irda_fir_crc32_serial u_crc (
    .clk        (clk),
    .rst_n      (wb_rst_n),
    .strobe_i   (fir_tx4_enable),
    .clr_i      (clrcrc),
    .crcndata_i (crcndata),
    .din_i      (txdin),
    .dout_o     (txdout)
  );

  // ---------------- 4PPM encoder ----------------
  logic [1:0] chip_cnt_q, chip_cnt_d;
  logic       half_q, half_d;
  logic       first_q, first_d;
  logic [1:0] pair_q, pair_d;
  logic       pair_valid_q, pair_valid_d;
  logic [3:0] symbol_q, symbol_d;
  logic       ppm_q, ppm_d;
  logic       sample;
  logic       pair_done;
  logic [1:0] pair_now;

  always_comb begin
    sample       = fir_tx4_enable & next_data_fir;
    pair_done    = sample & half_q;
    pair_now     = {first_q, txdout};
    chip_cnt_d   = chip_cnt_q;
    half_d       = half_q;
    first_d      = first_q;
    pair_d       = pair_q;
    pair_valid_d = pair_valid_q;
    symbol_d     = symbol_q;
    ppm_d        = ppm_q;
    if (ppm_restart) begin
      chip_cnt_d   = '0;
      half_d       = 1'b0;
      first_d      = 1'b0;
      pair_d       = '0;
      pair_valid_d = 1'b0;
      symbol_d     = '0;
      ppm_d        = 1'b0;
    end else begin
      if (sample) begin
        if (!half_q) begin
          half_d  = 1'b1;
          first_d = txdout;
        end else begin
          half_d       = 1'b0;
          pair_d       = pair_now;
          pair_valid_d = 1'b1;
        end
      end
      if (fir_tx8_enable) begin
        ppm_d      = symbol_q[~chip_cnt_q];
        chip_cnt_d = chip_cnt_q + 2'd1;
        // A pair finishing on the wrap strobe is used directly; no pair means an idle symbol.
        if (chip_cnt_q == 2'd3) begin
          if (pair_done)         symbol_d = ppm_symbol(pair_now);
          else if (pair_valid_q) symbol_d = ppm_symbol(pair_q);
          else                   symbol_d = 4'b0000;
          pair_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      chip_cnt_q   <= '0;
      half_q       <= 1'b0;
      first_q      <= 1'b0;
      pair_q       <= '0;
      pair_valid_q <= 1'b0;
      symbol_q     <= '0;
      ppm_q        <= 1'b0;
    end else begin
      chip_cnt_q   <= chip_cnt_d;
      half_q       <= half_d;
      first_q      <= first_d;
      pair_q       <= pair_d;
      pair_valid_q <= pair_valid_d;
      symbol_q     <= symbol_d;
      ppm_q        <= ppm_d;
    end
  end

  assign ppm_o = ppm_q;

endmodule

// File: tb/tb_irda_fir_tx_datapath.sv
// Self-checking bench for irda_fir_tx_datapath: a sequence-level reference model
// compared every cycle, plus directed literal checks on flags, CRC and 4PPM.
module tb_irda_fir_tx_datapath;

  logic       clk            = 1'b0;
  logic       wb_rst_n       = 1'b0;
  logic       fir_tx8_enable = 1'b0;
  logic       fir_tx4_enable = 1'b0;
  logic       fir_gen_start  = 1'b0;
  logic [1:0] fir_flag       = 2'b00;
  logic       clrcrc         = 1'b0;
  logic       crcndata       = 1'b0;
  logic       txdin          = 1'b0;
  logic       ppm_restart    = 1'b0;
  logic       next_data_fir  = 1'b0;
  logic       flag_gen_o, eof, txdout, ppm_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_n  = 0;
  bit          cmp_en = 1'b0;

  always #5 clk = ~clk;

  irda_fir_tx_datapath #(.PA_REPEAT(16)) dut (
    .clk            (clk),
    .wb_rst_n       (wb_rst_n),
    .fir_tx8_enable (fir_tx8_enable),
    .fir_tx4_enable (fir_tx4_enable),
    .fir_gen_start  (fir_gen_start),
    .fir_flag       (fir_flag),
    .flag_gen_o     (flag_gen_o),
    .eof            (eof),
    .clrcrc         (clrcrc),
    .crcndata       (crcndata),
    .txdin          (txdin),
    .txdout         (txdout),
    .ppm_restart    (ppm_restart),
    .next_data_fir  (next_data_fir),
    .ppm_o          (ppm_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [15:0] M_PA  = 16'h80A8;
  localparam logic [31:0] M_STA = 32'h0C0C_6060;
  localparam logic [31:0] M_STO = 32'h0C0C_0606;

  logic [1:0] m_flag   = 2'b00;
  int         m_len    = 0;
  int         m_pos    = 0;
  logic       m_flag_o = 1'b0;
  logic       m_eof    = 1'b0;
  bit         m_bits[$];
  int         m_outn   = 0;
  int         m_k      = 0;
  bit         m_half   = 1'b0;
  bit         m_first  = 1'b0;
  logic [1:0] m_pairs[$];
  logic [3:0] m_sym    = 4'b0000;
  logic       m_ppm    = 1'b0;
  logic       m_cur_tx;

  function automatic int flag_len(input logic [1:0] f);
    case (f)
      2'b01:   return 256;
      2'b10:   return 32;
      2'b11:   return 32;
      default: return 0;
    endcase
  endfunction

  function automatic logic flag_chip(input logic [1:0] f, input int p);
    case (f)
      2'b01:   return M_PA[15 - (p % 16)];
      2'b10:   return M_STA[31 - p];
      2'b11:   return M_STO[31 - p];
      default: return 1'b0;
    endcase
  endfunction

  // Textbook CRC-32 of a bit stream (preset ones, reflected, final inversion).
  function automatic logic [31:0] crc_of(input bit q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      if ((c[0] ^ q[i]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
      else                       c = c >> 1;
    end
    return ~c;
  endfunction

  function automatic logic exp_txdout();
    logic [31:0] c;
    if (!crcndata) return txdin;
    if (m_outn >= 32) return 1'b0;
    c = crc_of(m_bits);
    return c[m_outn];
  endfunction

  always @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m_flag = 2'b00; m_len = 0; m_pos = 0; m_flag_o = 1'b0; m_eof = 1'b0;
      m_bits.delete(); m_outn = 0;
      m_k = 0; m_half = 1'b0; m_first = 1'b0; m_pairs.delete(); m_sym = 4'b0000; m_ppm = 1'b0;
    end else begin
      m_cur_tx = exp_txdout();
      // flag sequence
      if (fir_gen_start) begin
        m_flag = fir_flag; m_len = flag_len(fir_flag); m_pos = 0; m_flag_o = 1'b0; m_eof = 1'b0;
      end else if (fir_tx8_enable && !m_eof) begin
        if (m_pos < m_len) begin
          m_flag_o = flag_chip(m_flag, m_pos);
          m_pos++;
        end else begin
          m_flag_o = 1'b0;
          m_eof    = 1'b1;
        end
      end
      // CRC bit stream
      if (fir_tx4_enable) begin
        if (clrcrc) begin
          m_bits.delete(); m_outn = 0;
        end else if (crcndata) begin
          m_outn++;
        end else begin
          m_bits.push_back(txdin);
        end
      end
      // 4PPM: symbol slot s occupies chips 4s+4..4s+7 after restart
      if (ppm_restart) begin
        m_k = 0; m_half = 1'b0; m_pairs.delete(); m_sym = 4'b0000; m_ppm = 1'b0;
      end else begin
        if (fir_tx4_enable && next_data_fir) begin
          if (!m_half) begin
            m_first = m_cur_tx; m_half = 1'b1;
          end else begin
            m_pairs.push_back({m_first, m_cur_tx}); m_half = 1'b0;
          end
        end
        if (fir_tx8_enable) begin
          m_ppm = m_sym[3 - (m_k % 4)];
          if (m_k % 4 == 3) begin
            if (m_pairs.size() != 0) m_sym = 4'b1000 >> m_pairs.pop_front();
            else                     m_sym = 4'b0000;
          end
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("flag_gen_o", flag_gen_o, m_flag_o);
      check("eof", eof, m_eof);
      check("ppm_o", ppm_o, m_ppm);
      check("txdout", txdout, exp_txdout());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    cyc_n++;
    fir_tx8_enable = (cyc_n % 2 == 0);
    fir_tx4_enable = (cyc_n % 4 == 0);
  endtask

  task automatic to_tx4();
    while (!fir_tx4_enable) cyc();
  endtask

  task automatic next_tx8();
    while (!fir_tx8_enable) cyc();
    cyc();
  endtask

  task automatic start_flag(input logic [1:0] f);
    fir_flag = f;
    fir_gen_start = 1'b1;
    cyc();
    fir_gen_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          qb[$];
    logic [255:0] chips;
    logic [31:0]  word;
    logic [19:0]  ppm_seq;
    logic [7:0]   pb;
    int           g;

    // model pin: CRC-32 check value of "123456789"
    for (int i = 0; i < 9; i++) begin
      logic [7:0] ch;
      ch = 8'h31 + 8'(i);
      for (int b = 0; b < 8; b++) qb.push_back(ch[b]);
    end
    check("model_crc_pin", crc_of(qb), 32'hCBF4_3926);

    cmp_en = 1'b1;
    cyc();
    cyc();
    check("rst_flag_gen_o", flag_gen_o, 1'b0);
    check("rst_eof", eof, 1'b0);
    check("rst_ppm_o", ppm_o, 1'b0);
    txdin = 1'b1;
    #1 check("rst_txdout_follows", txdout, 1'b1);
    txdin = 1'b0;
    cyc();
    wb_rst_n = 1'b1;
    next_tx8();
    check("idle_flag00_eof", eof, 1'b1);

    // preamble
    start_flag(2'b01);
    check("pa_start_eof", eof, 1'b0);
    for (int n = 0; n < 256; n++) begin
      next_tx8();
      chips[255 - n] = flag_gen_o;
    end
    check("pa_first16", chips[255:240], 16'h80A8);
    check("pa_last16", chips[15:0], 16'h80A8);
    check("pa_eof_at_256", eof, 1'b0);
    next_tx8();
    check("pa_eof_after_256", eof, 1'b1);
    repeat (5) next_tx8();
    check("pa_eof_hold", eof, 1'b1);
    check("pa_flag_zero_after", flag_gen_o, 1'b0);

    // STA then STO back to back
    start_flag(2'b10);
    check("sta_start_eof", eof, 1'b0);
    for (int n = 0; n < 32; n++) begin next_tx8(); word[31 - n] = flag_gen_o; end
    check("sta_chips", word, 32'h0C0C_6060);
    next_tx8();
    check("sta_eof", eof, 1'b1);
    start_flag(2'b11);
    check("sto_start_eof", eof, 1'b0);
    for (int n = 0; n < 32; n++) begin next_tx8(); word[31 - n] = flag_gen_o; end
    check("sto_chips", word, 32'h0C0C_0606);
    next_tx8();
    check("sto_eof", eof, 1'b1);

    // restart mid-sequence, then empty flag
    start_flag(2'b10);
    repeat (10) next_tx8();
    start_flag(2'b11);
    check("restart_mid_eof", eof, 1'b0);
    for (int n = 0; n < 32; n++) begin next_tx8(); word[31 - n] = flag_gen_o; end
    check("restart_mid_sto", word, 32'h0C0C_0606);
    start_flag(2'b00);
    check("none_start_eof", eof, 1'b0);
    next_tx8();
    check("none_eof_next", eof, 1'b1);

    // CRC over "123456789"
    to_tx4();
    clrcrc = 1'b1;
    cyc();
    clrcrc = 1'b0;
    foreach (qb[i]) begin
      to_tx4();
      txdin = qb[i];
      cyc();
    end
    txdin = 1'b0;
    crcndata = 1'b1;
    for (int n = 0; n < 32; n++) begin
      to_tx4();
      #1 word[n] = txdout;
      cyc();
    end
    check("crc_123456789", word, 32'hCBF4_3926);
    to_tx4();
    #1 check("crc_drained_zero", txdout, 1'b0);
    cyc();
    crcndata = 1'b0;
    to_tx4();
    clrcrc = 1'b1;
    cyc();
    clrcrc = 1'b0;

    // 4PPM: restart on a no-strobe cycle so the next strobe carries a bit
    to_tx4();
    cyc(); cyc(); cyc();
    ppm_restart = 1'b1;
    cyc();
    ppm_restart = 1'b0;
    pb = 8'b0011_0110;
    for (int j = 0; j < 20; j++) begin
      if (fir_tx4_enable && j < 16) begin
        txdin = pb[7 - j / 2];
        next_data_fir = 1'b1;
      end else begin
        next_data_fir = 1'b0;
      end
      cyc();
      ppm_seq[19 - j] = ppm_o;
      next_data_fir = 1'b0;
      cyc();
    end
    check("ppm_sequence", ppm_seq, 20'b0000_1000_0001_0100_0010);

    // restart mid-symbol
    txdin = 1'b0;
    to_tx4(); next_data_fir = 1'b1; cyc(); next_data_fir = 1'b0;
    to_tx4(); next_data_fir = 1'b1; cyc(); next_data_fir = 1'b0;
    g = 0;
    while (ppm_o !== 1'b1 && g < 40) begin cyc(); g++; end
    check("ppm_reached_one", ppm_o, 1'b1);
    ppm_restart = 1'b1;
    cyc();
    ppm_restart = 1'b0;
    check("ppm_restart_clear", ppm_o, 1'b0);
    repeat (8) next_tx8();
    check("ppm_idle_zero", ppm_o, 1'b0);

    // async reset in the middle of a preamble
    start_flag(2'b01);
    g = 0;
    while (flag_gen_o !== 1'b1 && g < 40) begin next_tx8(); g++; end
    repeat (3) next_tx8();
    check("pa_running_eof", eof, 1'b0);
    g = 0;
    while (flag_gen_o !== 1'b1 && g < 40) begin next_tx8(); g++; end
    check("pa_running_one", flag_gen_o, 1'b1);
    wb_rst_n = 1'b0;
    #1;
    check("async_rst_flag", flag_gen_o, 1'b0);
    check("async_rst_eof", eof, 1'b0);
    check("async_rst_ppm", ppm_o, 1'b0);
    cyc();
    wb_rst_n = 1'b1;
    next_tx8();
    check("post_rst_eof", eof, 1'b1);
    repeat (4) cyc();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
